// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: the instruction buffer entry and its default depth.
package cpu_pkg;

  localparam int INST_FIFO_DEPTH = 16;
  localparam int CPU_PC_W        = 32;
  localparam int CPU_INST_W      = 32;

  typedef struct packed {
    logic [CPU_PC_W-1:0]   pc;
    logic [CPU_INST_W-1:0] inst;
    logic                  adel;
  } inst_fifo_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Fetch-to-decode instruction buffer: up to two pushes and two pops per cycle.
// The two oldest entries are presented as master/slave issue candidates.
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH  = INST_FIFO_DEPTH,
  parameter int PC_W   = CPU_PC_W,
  parameter int INST_W = CPU_INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              write_en1,
  input  logic              write_en2,
  input  logic [PC_W-1:0]   write_pc1,
  input  logic [INST_W-1:0] write_inst1,
  input  logic              write_adel1,
  input  logic [PC_W-1:0]   write_pc2,
  input  logic [INST_W-1:0] write_inst2,
  input  logic              write_adel2,
  input  logic              read_en1,
  input  logic              read_en2,
  output logic [PC_W-1:0]   master_pc,
  output logic [INST_W-1:0] master_inst,
  output logic              master_adel,
  output logic [PC_W-1:0]   slave_pc,
  output logic [INST_W-1:0] slave_inst,
  output logic              slave_adel,
  output logic              fifo_empty,
  output logic              fifo_almost_empty,
  output logic              fifo_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       pushes, pops;
  inst_fifo_entry_t ent1, ent2;
  inst_fifo_entry_t mem_q [DEPTH];

  assign fifo_empty        = (count_q == '0);
  assign fifo_almost_empty = (count_q == CNT_W'(1));
  assign fifo_full         = (count_q >= CNT_W'(DEPTH - 1));

  assign ent1     = '{pc: write_pc1, inst: write_inst1, adel: write_adel1};
  assign ent2     = '{pc: write_pc2, inst: write_inst2, adel: write_adel2};
  assign head_nxt = head_q + PTR_W'(1);

  // Full is judged before this cycle's pops, so a push never lands on live data.
  always_comb begin
    pushes = 2'd0;
    if (!fifo_full && write_en1) pushes = write_en2 ? 2'd2 : 2'd1;
    pops = 2'd0;
    if (read_en1 && !fifo_empty) pops = (read_en2 && count_q >= CNT_W'(2)) ? 2'd2 : 2'd1;
    head_d  = head_q + PTR_W'(pops);
    tail_d  = tail_q + PTR_W'(pushes);
    count_d = count_q + CNT_W'(pushes) - CNT_W'(pops);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; stale contents are hidden by the count gating below.
  always_ff @(posedge clk) begin
    if (!flush && pushes != 2'd0) begin
      mem_q[tail_q] <= ent1;
      if (pushes == 2'd2) mem_q[tail_q + PTR_W'(1)] <= ent2;
    end
  end

  always_comb begin
    master_pc   = '0;
    master_inst = '0;
    master_adel = 1'b0;
    slave_pc    = '0;
    slave_inst  = '0;
    slave_adel  = 1'b0;
    if (count_q >= CNT_W'(1)) begin
      master_pc   = mem_q[head_q].pc;
      master_inst = mem_q[head_q].inst;
      master_adel = mem_q[head_q].adel;
    end
    if (count_q >= CNT_W'(2)) begin
      slave_pc   = mem_q[head_nxt].pc;
      slave_inst = mem_q[head_nxt].inst;
      slave_adel = mem_q[head_nxt].adel;
    end
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: queue model checked every cycle, a directed vector
// table, and hand sequences for full, streaming, flush and async reset.
module tb_inst_fifo;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  typedef struct {
    logic        w1, w2, r1, r2, fl;
    ent_t        e1, e2;
    logic [31:0] exp_mpc, exp_spc, exp_sinst;
    logic        exp_e, exp_ae, exp_f;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, write_en1, write_en2, write_adel1, write_adel2, read_en1, read_en2;
  logic [31:0] write_pc1, write_inst1, write_pc2, write_inst2;
  logic [31:0] master_pc, master_inst, slave_pc, slave_inst;
  logic        master_adel, slave_adel, fifo_empty, fifo_almost_empty, fifo_full;

  int   total = 0;
  int   bad   = 0;
  ent_t sb[$];
  logic [31:0] popped[$];

  always #5 clk = ~clk;

  inst_fifo #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_pc1(write_pc1), .write_inst1(write_inst1), .write_adel1(write_adel1),
    .write_pc2(write_pc2), .write_inst2(write_inst2), .write_adel2(write_adel2),
    .read_en1(read_en1), .read_en2(read_en2),
    .master_pc(master_pc), .master_inst(master_inst), .master_adel(master_adel),
    .slave_pc(slave_pc), .slave_inst(slave_inst), .slave_adel(slave_adel),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty), .fifo_full(fifo_full)
  );

  always @(negedge clk) if (rst_n) assert (dut.count_q <= 5'(DEPTH));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    ent_t e;
    e.pc = pc; e.inst = inst; e.adel = adel;
    return e;
  endfunction

  task automatic cmp_model();
    ent_t m, s;
    m = '0; s = '0;
    if (sb.size() >= 1) m = sb[0];
    if (sb.size() >= 2) s = sb[1];
    chk("master_pc",   master_pc,   m.pc);
    chk("master_inst", master_inst, m.inst);
    chk("master_adel", master_adel, m.adel);
    chk("slave_pc",    slave_pc,    s.pc);
    chk("slave_inst",  slave_inst,  s.inst);
    chk("slave_adel",  slave_adel,  s.adel);
    chk("empty",        fifo_empty,        sb.size() == 0);
    chk("almost_empty", fifo_almost_empty, sb.size() == 1);
    chk("full",         fifo_full,         sb.size() >= DEPTH - 1);
  endtask

  // One clock: check current outputs against the model, update the model
  // with this cycle's stimulus, then advance past the edge.
  task automatic cycle(input logic w1, input logic w2, input ent_t e1, input ent_t e2,
                       input logic r1, input logic r2, input logic fl);
    int n, pops;
    bit full;
    write_en1 = w1; write_en2 = w2; flush = fl;
    write_pc1 = e1.pc; write_inst1 = e1.inst; write_adel1 = e1.adel;
    write_pc2 = e2.pc; write_inst2 = e2.inst; write_adel2 = e2.adel;
    read_en1 = r1; read_en2 = r2;
    cmp_model();
    n    = sb.size();
    full = (n >= DEPTH - 1);
    pops = !r1 ? 0 : (r2 && n >= 2) ? 2 : (n >= 1 ? 1 : 0);
    if (fl) sb.delete();
    else begin
      repeat (pops) begin
        popped.push_back(sb[0].pc);
        void'(sb.pop_front());
      end
      if (!full && w1) begin
        sb.push_back(e1);
        if (w2) sb.push_back(e2);
      end
    end
    @(posedge clk);
    #1;
    write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0; flush = 0;
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, 0, 0, 0);
  endtask

  vec_t vt[5];

  initial begin
    rst_n = 0; flush = 0; write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0;
    write_pc1 = 0; write_inst1 = 0; write_adel1 = 0;
    write_pc2 = 0; write_inst2 = 0; write_adel2 = 0;
    #12;
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_almost_empty", fifo_almost_empty, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_master_pc", master_pc, 32'h0);
    chk("rst_slave_inst", slave_inst, 32'h0);
    rst_n = 1;
    @(posedge clk); #1;
    idle();

    // Directed vectors; expected values are the outputs after the edge.
    vt[0] = '{1, 1, 0, 0, 0, mk(32'hBFC00000, 32'h24080001, 0), mk(32'hBFC00004, 32'h24090002, 1),
              32'hBFC00000, 32'hBFC00004, 32'h24090002, 0, 0, 0};
    vt[1] = '{0, 0, 1, 0, 0, '0, '0, 32'hBFC00004, 32'h0, 32'h0, 0, 1, 0};
    vt[2] = '{0, 0, 1, 1, 0, '0, '0, 32'h0, 32'h0, 32'h0, 1, 0, 0};
    vt[3] = '{0, 1, 0, 0, 0, '0, mk(32'h11110000, 32'h1, 0), 32'h0, 32'h0, 32'h0, 1, 0, 0};
    vt[4] = '{1, 0, 1, 1, 0, mk(32'hBFC00010, 32'h3C1DBFC0, 1), '0, 32'hBFC00010, 32'h0, 32'h0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      cycle(vt[i].w1, vt[i].w2, vt[i].e1, vt[i].e2, vt[i].r1, vt[i].r2, vt[i].fl);
      chk($sformatf("vec%0d_master_pc", i), master_pc, vt[i].exp_mpc);
      chk($sformatf("vec%0d_slave_pc", i), slave_pc, vt[i].exp_spc);
      chk($sformatf("vec%0d_slave_inst", i), slave_inst, vt[i].exp_sinst);
      chk($sformatf("vec%0d_empty", i), fifo_empty, vt[i].exp_e);
      chk($sformatf("vec%0d_almost_empty", i), fifo_almost_empty, vt[i].exp_ae);
      chk($sformatf("vec%0d_full", i), fifo_full, vt[i].exp_f);
    end
    cycle(0, 0, '0, '0, 1, 0, 0);
    chk("drain_empty", fifo_empty, 1'b1);

    // Fill to 15, then a pair push with a double pop: push must be dropped.
    for (int i = 0; i < 7; i++)
      cycle(1, 1, mk(32'h2000 + 8 * i, 32'hA000 + i, 0), mk(32'h2004 + 8 * i, 32'hB000 + i, 0), 0, 0, 0);
    chk("fourteen_not_full", fifo_full, 1'b0);
    cycle(1, 0, mk(32'h2038, 32'hC000, 1), '0, 0, 0, 0);
    chk("fifteen_full", fifo_full, 1'b1);
    popped.delete();
    cycle(1, 1, mk(32'h9000, 32'hDEAD, 0), mk(32'h9004, 32'hBEEF, 0), 1, 1, 0);
    chk("thirteen_not_full", fifo_full, 1'b0);
    chk("thirteen_master", master_pc, 32'h2008);
    for (int i = 0; i < 20 && !fifo_empty; i++) cycle(0, 0, '0, '0, 1, 1, 0);
    chk("full_drain_empty", fifo_empty, 1'b1);
    chk("full_drain_count", popped.size(), 15);
    begin
      int dropped_seen = 0;
      foreach (popped[i]) if (popped[i] == 32'h9000 || popped[i] == 32'h9004) dropped_seen++;
      chk("dropped_never_seen", dropped_seen, 0);
    end

    // Random stream of 100 sequential pcs across several wraps.
    begin
      int pushed = 0;
      int np, rp;
      logic [31:0] pc;
      popped.delete();
      for (int c = 0; c < 3000 && (pushed < 100 || sb.size() > 0); c++) begin
        np = $urandom_range(0, 2);
        if (sb.size() >= DEPTH - 1) np = 0;
        if (np > 100 - pushed) np = 100 - pushed;
        rp = $urandom_range(0, 2);
        pc = 32'h8000_0000 + 32'(4 * pushed);
        cycle(np >= 1, np == 2, mk(pc, pc ^ 32'h5A5A_0000, 1'($urandom_range(0, 1))),
              mk(pc + 4, (pc + 4) ^ 32'h5A5A_0000, 1'($urandom_range(0, 1))), rp >= 1, rp == 2, 0);
        pushed += np;
      end
      chk("stream_pushed", pushed, 100);
      chk("stream_popped", popped.size(), 100);
      foreach (popped[i]) chk($sformatf("stream_pc%0d", i), popped[i], 32'h8000_0000 + 32'(4 * i));
      chk("stream_empty", fifo_empty, 1'b1);
    end

    // Flush at count 6 with a simultaneous pair push and double pop.
    for (int i = 0; i < 3; i++)
      cycle(1, 1, mk(32'h3000 + 8 * i, 32'h1, 0), mk(32'h3004 + 8 * i, 32'h2, 0), 0, 0, 0);
    cycle(1, 1, mk(32'h4000, 32'h3, 0), mk(32'h4004, 32'h4, 0), 1, 1, 1);
    chk("flush_empty", fifo_empty, 1'b1);
    chk("flush_master_pc", master_pc, 32'h0);
    cycle(1, 0, mk(32'h5000, 32'h5, 0), '0, 0, 0, 0);
    chk("post_flush_one", fifo_almost_empty, 1'b1);
    chk("post_flush_pc", master_pc, 32'h5000);

    // Async reset with count 9, observed before the next edge.
    for (int i = 0; i < 4; i++)
      cycle(1, 1, mk(32'h6000 + 8 * i, 32'h6, 1), mk(32'h6004 + 8 * i, 32'h7, 0), 0, 0, 0);
    cmp_model();
    #3 rst_n = 0;
    #1;
    chk("arst_empty", fifo_empty, 1'b1);
    chk("arst_almost_empty", fifo_almost_empty, 1'b0);
    chk("arst_full", fifo_full, 1'b0);
    chk("arst_master_pc", master_pc, 32'h0);
    chk("arst_slave_pc", slave_pc, 32'h0);
    sb.delete();
    #1 rst_n = 1;
    @(posedge clk); #1;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Instruction buffer between the fetch stage and the dual-issue decode stage.
- Fetch pushes up to two {pc, inst, fetch-exception} entries per cycle.
- Decode sees the two oldest entries as master and slave candidates, then pops one or two according to the issue decision.
- Provides the empty, almost_empty and full flags that the dual-issue detector and fetch stall logic consume.

Parameters:
DEPTH  16  number of entries; power of two, >= 4
PC_W  32  width of the pc field
INST_W  32  width of the instruction word

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  discard all contents (branch mispredict, exception)
write_en1  in  1  push entry 1
write_en2  in  1  push entry 2; only honoured together with write_en1
write_pc1  in  PC_W  pc of entry 1 (older)
write_inst1  in  INST_W  instruction of entry 1
write_adel1  in  1  fetch address error flag of entry 1
write_pc2  in  PC_W  pc of entry 2
write_inst2  in  INST_W  instruction of entry 2
write_adel2  in  1  fetch address error flag of entry 2
read_en1  in  1  master issued, pop one
read_en2  in  1  slave also issued, pop a second entry; only honoured together with read_en1
master_pc  out  PC_W  pc of head entry
master_inst  out  INST_W  instruction of head entry
master_adel  out  1  address error flag of head entry
slave_pc  out  PC_W  pc of head+1 entry
slave_inst  out  INST_W  instruction of head+1 entry
slave_adel  out  1  address error flag of head+1 entry
fifo_empty  out  1  count == 0
fifo_almost_empty  out  1  count == 1
fifo_full  out  1  count >= DEPTH-1 (fewer than two free slots)

Behaviour:
- State: head pointer, tail pointer (log2(DEPTH) bits, natural wrap) and count (log2(DEPTH)+1 bits). Storage array is not reset.
- Reset (rst_n low, asynchronous):
  - head = tail = count = 0.
  - fifo_empty=1, fifo_almost_empty=0, fifo_full=0.
  - All data outputs 0.
- Outputs are combinational from registered state:
  - master_* = mem[head] if count >= 1, else all zero.
  - slave_* = mem[head+1 mod DEPTH] if count >= 2, else all zero.
- Flags are decoded from the registered count only.
- Write acceptance, in effect when fifo_full is 0 at the clock edge:
  - write_en1 only: mem[tail] = entry1, tail += 1.
  - write_en1 and write_en2: mem[tail] = entry1, mem[tail+1] = entry2, tail += 2.
  - write_en2 without write_en1: ignored.
  - fifo_full=1: all writes dropped, even if a pop occurs in the same cycle. Fetch is required to stall on fifo_full.
- Pop, evaluated against the pre-edge count:
  - pops = 0 if read_en1=0.
  - pops = 1 if read_en1=1 and (read_en2=0 or count < 2).
  - pops = 2 if read_en1, read_en2 and count >= 2.
  - read_en1 with count=0: ignored.
  - head += pops.
- Simultaneous write and pop:
  - count_next = count + pushes - pops.
  - No bypass: data written this cycle becomes visible on master/slave from the next cycle.
  - Writing into a slot being popped the same cycle is legal. Full is checked before pops, so overwrite of live data cannot occur.
- Flush: synchronous and dominant over write and read in the same cycle. Next state is head = tail = count = 0, and any same-cycle writes are discarded.
- Ordering: entries leave strictly in push order; entry 1 is older than entry 2.
- Wrap-around at DEPTH is transparent to ordering and to the flags.
- No stored value for count exceeds DEPTH; an assertion in the bench checks count <= DEPTH.
- Reset mid-operation: immediate return to reset state regardless of clock. No entry survives; storage contents are irrelevant because outputs are gated by count.

Decomposition:
- Shared package (cpu_pkg):
  - typedef inst_fifo_entry_t, a packed struct {pc, inst, adel}.
  - constant INST_FIFO_DEPTH = 16.
- No sub-module: storage is a flat array of inst_fifo_entry_t inside this block, with a pointer/count control always_ff and an output decode always_comb.

Test Plan:
- Reset then idle -> fifo_empty=1, fifo_almost_empty=0, fifo_full=0, master_pc=0, slave_inst=0.
- Push pair (0xBFC00000/0x24080001, 0xBFC00004/0x24090002) -> next cycle:
  - master_pc=0xBFC00000, slave_pc=0xBFC00004, slave_inst=0x24090002.
  - fifo_empty=0, fifo_almost_empty=0.
- From that state, read_en1 only -> master_pc=0xBFC00004, slave_* = 0, fifo_almost_empty=1. Then read_en1+read_en2 with count=1 -> only one pop, fifo_empty=1.
- Push pairs until count=15 -> fifo_full=1. Then push pair + pop 2 in the same cycle -> count=13, pushed pcs never appear at the outputs.
- Stream 100 sequential pcs (step 4) with random push 0/1/2 and random pop 0/1/2 across several wraps -> master_pc sequence strictly increasing by 4, no gaps or duplicates, flags always consistent with the scoreboard count.
- With count=6, assert flush together with a write pair and read_en1+read_en2 -> next cycle fifo_empty=1, count=0, master_pc=0. Then drop rst_n mid-stream with count=9 -> flags return to reset values asynchronously, before the next clock edge.
